// File: rtl/fp_status_monitor.sv
// Watches a floating-point status flag vector for pairs of flags that must never be
// raised together, keeping per-pair live/sticky/count state and a first-violation capture.
module fp_status_monitor #(
  parameter int W = 8,
  parameter int NPAIR = 6,
  parameter logic [NPAIR*2*$clog2(W)-1:0] PAIR_TABLE = {3'd3, 3'd4, 3'd2, 3'd3, 3'd1, 3'd3,
                                                        3'd0, 3'd4, 3'd0, 3'd2, 3'd0, 3'd1},
  parameter int CNT_W = 8,
  parameter int TS_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             status,
  input  logic                     status_valid,
  input  logic                     en,
  input  logic                     halt_mode,
  input  logic                     clear,
  output logic [NPAIR-1:0]         viol_now,
  output logic [NPAIR-1:0]         viol_sticky,
  output logic [NPAIR*CNT_W-1:0]   viol_cnt,
  output logic                     first_valid,
  output logic [$clog2(NPAIR)-1:0] first_pair,
  output logic [TS_W-1:0]          first_ts,
  output logic [1:0]               state
);

  localparam int IW = $clog2(W);
  localparam int PW = $clog2(NPAIR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t             state_q;
  logic [NPAIR-1:0]   now_q;
  logic [NPAIR-1:0]   sticky_q;
  logic [CNT_W-1:0]   cnt_q [NPAIR];
  logic [TS_W-1:0]    ts_q;
  logic               first_valid_q;
  logic [PW-1:0]      first_pair_q;
  logic [TS_W-1:0]    first_ts_q;

  logic               accept;
  logic [NPAIR-1:0]   hit;
  logic [NPAIR-1:0]   viol;
  logic [PW-1:0]      low_idx;

  assign accept = (state_q == RUN) && status_valid && !clear;
  assign viol   = accept ? hit : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NPAIR; gi++) begin : g_pair
      localparam int A = int'(PAIR_TABLE[gi*2*IW+IW +: IW]);
      localparam int B = int'(PAIR_TABLE[gi*2*IW +: IW]);
      // Table entries that point past the status vector can never fire.
      if (A < W && B < W) begin : g_valid
        assign hit[gi] = status[A] & status[B];
      end else begin : g_unused
        assign hit[gi] = 1'b0;
      end
      assign viol_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
  endgenerate

  always_comb begin
    low_idx = '0;
    for (int k = NPAIR - 1; k >= 0; k--) begin
      if (viol[k]) low_idx = k[PW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      now_q         <= '0;
      sticky_q      <= '0;
      ts_q          <= '0;
      first_valid_q <= 1'b0;
      first_pair_q  <= '0;
      first_ts_q    <= '0;
      for (int k = 0; k < NPAIR; k++) cnt_q[k] <= '0;
    end else begin
      now_q <= viol;
      if (clear) begin
        sticky_q      <= '0;
        ts_q          <= '0;
        first_valid_q <= 1'b0;
        first_pair_q  <= '0;
        first_ts_q    <= '0;
        for (int k = 0; k < NPAIR; k++) cnt_q[k] <= '0;
        state_q       <= en ? RUN : IDLE;
      end else begin
        sticky_q <= sticky_q | viol;
        for (int k = 0; k < NPAIR; k++) begin
          if (viol[k] && cnt_q[k] != {CNT_W{1'b1}}) cnt_q[k] <= cnt_q[k] + 1'b1;
        end
        if (accept) ts_q <= ts_q + 1'b1;
        if (!first_valid_q && |viol) begin
          first_valid_q <= 1'b1;
          first_pair_q  <= low_idx;
          first_ts_q    <= ts_q;
        end
        // A halting violation wins over a simultaneous drop of en.
        case (state_q)
          IDLE:    if (en) state_q <= RUN;
          RUN: begin
            if (|viol && halt_mode) state_q <= HALT;
            else if (!en)           state_q <= IDLE;
          end
          HALT:    state_q <= HALT;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign viol_now    = now_q;
  assign viol_sticky = sticky_q;
  assign first_valid = first_valid_q;
  assign first_pair  = first_pair_q;
  assign first_ts    = first_ts_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fp_status_monitor.sv
// Scoreboard bench for fp_status_monitor: a default instance and a narrow-counter /
// narrow-timestamp instance share stimulus and are checked against a behavioural model.
module tb_fp_status_monitor;

  typedef struct packed {
    logic [1:0]      st;
    logic [5:0]      now;
    logic [5:0]      sticky;
    logic [5:0][7:0] cnt;
    logic            fv;
    logic [2:0]      fp;
    logic [15:0]     fts;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, status_valid, en, halt_mode, clear;
  logic [7:0]  status;

  logic [5:0]  now0, sticky0, now1, sticky1;
  logic [47:0] cnt0;
  logic [11:0] cnt1;
  logic        fv0, fv1;
  logic [2:0]  fp0, fp1;
  logic [15:0] fts0;
  logic [2:0]  fts1;
  logic [1:0]  st0, st1;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb[$];

  int PA[6]  = '{0, 0, 0, 1, 2, 3};
  int PB[6]  = '{1, 2, 4, 3, 3, 4};
  int CW[2]  = '{8, 2};
  int TWW[2] = '{16, 3};

  int m_state[2], m_now[2], m_sticky[2], m_ts[2], m_fv[2], m_fp[2], m_fts[2];
  int m_cnt[2][6];

  always #5 clk = ~clk;

  fp_status_monitor dut0 (
    .clk(clk), .rst(rst), .status(status), .status_valid(status_valid), .en(en),
    .halt_mode(halt_mode), .clear(clear), .viol_now(now0), .viol_sticky(sticky0),
    .viol_cnt(cnt0), .first_valid(fv0), .first_pair(fp0), .first_ts(fts0), .state(st0)
  );

  fp_status_monitor #(.CNT_W(2), .TS_W(3)) dut1 (
    .clk(clk), .rst(rst), .status(status), .status_valid(status_valid), .en(en),
    .halt_mode(halt_mode), .clear(clear), .viol_now(now1), .viol_sticky(sticky1),
    .viol_cnt(cnt1), .first_valid(fv1), .first_pair(fp1), .first_ts(fts1), .state(st1)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(int c, logic r, logic [7:0] s, logic sv, logic e, logic hm, logic cl);
    logic       acc;
    logic [5:0] v;
    int         lo;
    if (r) begin
      m_state[c] = 0; m_now[c] = 0; m_sticky[c] = 0; m_ts[c] = 0;
      m_fv[c] = 0; m_fp[c] = 0; m_fts[c] = 0;
      for (int k = 0; k < 6; k++) m_cnt[c][k] = 0;
      return;
    end
    acc = (m_state[c] == 1) && sv && !cl;
    v = '0;
    for (int k = 0; k < 6; k++) if (acc && s[PA[k]] && s[PB[k]]) v[k] = 1'b1;
    m_now[c] = int'(v);
    if (cl) begin
      m_sticky[c] = 0; m_ts[c] = 0; m_fv[c] = 0; m_fp[c] = 0; m_fts[c] = 0;
      for (int k = 0; k < 6; k++) m_cnt[c][k] = 0;
      m_state[c] = e ? 1 : 0;
      return;
    end
    m_sticky[c] = m_sticky[c] | int'(v);
    for (int k = 0; k < 6; k++)
      if (v[k] && m_cnt[c][k] < (1 << CW[c]) - 1) m_cnt[c][k]++;
    if (v != 0 && m_fv[c] == 0) begin
      lo = 0;
      for (int k = 5; k >= 0; k--) if (v[k]) lo = k;
      m_fv[c] = 1; m_fp[c] = lo; m_fts[c] = m_ts[c];
    end
    if (acc) m_ts[c] = (m_ts[c] + 1) % (1 << TWW[c]);
    if (m_state[c] == 0) begin
      if (e) m_state[c] = 1;
    end else if (m_state[c] == 1) begin
      if (v != 0 && hm) m_state[c] = 2;
      else if (!e)      m_state[c] = 0;
    end
  endtask

  function automatic exp_t snap(int c);
    exp_t x;
    x.st = 2'(m_state[c]); x.now = 6'(m_now[c]); x.sticky = 6'(m_sticky[c]);
    for (int k = 0; k < 6; k++) x.cnt[k] = 8'(m_cnt[c][k]);
    x.fv = 1'(m_fv[c]); x.fp = 3'(m_fp[c]); x.fts = 16'(m_fts[c]);
    return x;
  endfunction

  function automatic exp_t obs(int c);
    exp_t o;
    if (c == 0) begin
      o.st = st0; o.now = now0; o.sticky = sticky0; o.fv = fv0; o.fp = fp0; o.fts = fts0;
      for (int k = 0; k < 6; k++) o.cnt[k] = cnt0[k*8 +: 8];
    end else begin
      o.st = st1; o.now = now1; o.sticky = sticky1; o.fv = fv1; o.fp = fp1;
      o.fts = {13'b0, fts1};
      for (int k = 0; k < 6; k++) o.cnt[k] = {6'b0, cnt1[k*2 +: 2]};
    end
    return o;
  endfunction

  task automatic step(logic r, logic [7:0] s, logic sv, logic e, logic hm, logic cl);
    exp_t ex;
    exp_t o;
    rst = r; status = s; status_valid = sv; en = e; halt_mode = hm; clear = cl;
    for (int c = 0; c < 2; c++) begin
      model(c, r, s, sv, e, hm, cl);
      sb.push_back(snap(c));
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      ex = sb.pop_front();
      o  = obs(c);
      check($sformatf("i%0d state", c), 64'(o.st), 64'(ex.st));
      check($sformatf("i%0d viol_now", c), 64'(o.now), 64'(ex.now));
      check($sformatf("i%0d viol_sticky", c), 64'(o.sticky), 64'(ex.sticky));
      for (int k = 0; k < 6; k++)
        check($sformatf("i%0d viol_cnt[%0d]", c, k), 64'(o.cnt[k]), 64'(ex.cnt[k]));
      check($sformatf("i%0d first_valid", c), 64'(o.fv), 64'(ex.fv));
      check($sformatf("i%0d first_pair", c), 64'(o.fp), 64'(ex.fp));
      check($sformatf("i%0d first_ts", c), 64'(o.fts), 64'(ex.fts));
    end
    $display("[TB] rst=%0b st=%02h v=%0b en=%0b hm=%0b clr=%0b -> state=%0d now=%02h cnt=%012h",
             r, s, sv, e, hm, cl, st0, now0, cnt0);
  endtask

  initial begin
    step(1, 8'h00, 0, 0, 0, 0);
    check("reset state", 64'(st0), 64'd0);
    check("reset cnt", 64'(cnt0), 64'd0);
    step(1, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0);
    check("idle to run", 64'(st0), 64'd1);

    step(0, 8'h01, 1, 1, 0, 0);
    step(0, 8'h20, 1, 1, 0, 0);
    check("clean sample no viol", 64'(now0), 64'd0);
    step(0, 8'h03, 1, 1, 0, 0);
    check("pair0 viol_now", 64'(now0), 64'h01);
    check("pair0 cnt", 64'(cnt0[7:0]), 64'd1);
    check("pair0 first_pair", 64'(fp0), 64'd0);
    check("pair0 first_ts", 64'(fts0), 64'd2);

    step(0, 8'h05, 1, 1, 0, 1);
    check("clear viol_now", 64'(now0), 64'd0);
    check("clear sticky", 64'(sticky0), 64'd0);
    check("clear cnt", 64'(cnt0), 64'd0);
    check("clear first_valid", 64'(fv0), 64'd0);
    check("clear state run", 64'(st0), 64'd1);

    for (int i = 0; i < 5; i++) step(0, 8'h18, 1, 1, 0, 0);
    check("sat cnt5 narrow", 64'(cnt1[11:10]), 64'd3);
    check("cnt5 wide", 64'(cnt0[47:40]), 64'd5);
    check("sticky5 narrow", 64'(sticky1[5]), 64'd1);

    step(0, 8'h00, 0, 1, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 8'h20, 1, 1, 0, 0);
    step(0, 8'h0C, 1, 1, 0, 0);
    check("wrap first_pair", 64'(fp1), 64'd4);
    check("wrap first_ts", 64'(fts1), 64'd1);
    check("nowrap first_ts", 64'(fts0), 64'd9);

    step(0, 8'h00, 0, 1, 1, 1);
    step(0, 8'h1F, 1, 1, 1, 0);
    check("all pairs viol_now", 64'(now0), 64'h3F);
    check("all pairs first_pair", 64'(fp0), 64'd0);
    check("halt entered", 64'(st0), 64'd2);
    step(0, 8'h03, 1, 1, 1, 0);
    check("halt viol_now", 64'(now0), 64'd0);
    check("halt cnt frozen", 64'(cnt0[7:0]), 64'd1);
    step(0, 8'h03, 1, 0, 1, 0);
    check("halt ignores en", 64'(st0), 64'd2);

    step(1, 8'h03, 1, 1, 1, 1);
    check("rst from halt state", 64'(st0), 64'd0);
    check("rst from halt cnt", 64'(cnt0), 64'd0);
    check("rst from halt fv", 64'(fv0), 64'd0);

    for (int i = 0; i < 250; i++) begin
      step(($urandom_range(0, 49) == 0), 8'($urandom & $urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_status_monitor.md
FP_STATUS_MONITOR -- requirements
Module: fp_status_monitor

Interface
REQ-001 Parameter W, default 8: status vector width, min 5.
REQ-002 Parameter NPAIR, default 6: number of mutually exclusive flag pairs checked.
REQ-003 Parameter PAIR_TABLE, default {(0,1),(0,2),(0,4),(1,3),(2,3),(3,4)}: packed NPAIR entries of two bit indices, each $clog2(W) wide; entry k = (a_k,b_k).
REQ-004 Parameter CNT_W, default 8: per-pair violation counter width.
REQ-005 Parameter TS_W, default 16: sample timestamp width.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 status  input  W  flag vector, bit0 zero, bit1 inf, bit2 nan, bit3 tiny, bit4 huge, bit5 inexact, upper bits reserved.
REQ-009 status_valid  input  1  status is a valid result this cycle.
REQ-010 en  input  1  monitoring enable.
REQ-011 halt_mode  input  1  0 = continuous, 1 = freeze on first violation.
REQ-012 clear  input  1  synchronous clear of sticky flags, counters, capture, HALT.
REQ-013 viol_now  output  NPAIR  per-pair violation of the previous accepted sample.
REQ-014 viol_sticky  output  NPAIR  accumulated violations since reset/clear.
REQ-015 viol_cnt  output  NPAIR*CNT_W  per-pair counters, pair k at bits [k*CNT_W +: CNT_W].
REQ-016 first_valid, first_pair ($clog2(NPAIR)), first_ts (TS_W)  outputs  first-violation capture.
REQ-017 state  output  2  IDLE=0, RUN=1, HALT=2.

Function
REQ-018 A sample is accepted when state==RUN and status_valid==1 and clear==0.
REQ-019 Pair k violates when the accepted sample has status[a_k] && status[b_k].
REQ-020 All outputs are registered; viol_now/sticky/cnt/capture reflect an accepted sample one cycle after acceptance.
REQ-021 viol_now updates on every accepted sample and is 0 in cycles following a non-accepted cycle.
REQ-022 viol_sticky[k] sets on violation of pair k and holds until clear or rst.
REQ-023 viol_cnt[k] increments by 1 per violating accepted sample and saturates at 2^CNT_W-1.
REQ-024 Timestamp counter ts increments by 1 per accepted sample, wraps 2^TS_W-1 -> 0; the sample's ts is its value before increment.
REQ-025 On first violation after reset/clear: first_valid=1, first_pair = lowest violating k, first_ts = that sample's ts; later violations do not change capture.
REQ-026 FSM: IDLE->RUN when en=1; RUN->IDLE when en=0; RUN->HALT when a sample violates and halt_mode=1; HALT->IDLE on clear (en=0) or HALT->RUN on clear (en=1); en is ignored in HALT.
REQ-027 In HALT no samples are accepted; ts, counters, sticky, capture frozen; viol_now=0.
REQ-028 clear takes priority over a simultaneous violation: sample discarded, all state cleared, ts reset to 0.
REQ-029 Reserved status bits and bits not named in PAIR_TABLE never cause a violation.

Reset
REQ-030 On rst: state=IDLE, viol_now=0, viol_sticky=0, viol_cnt=0, ts=0, first_valid=0, first_pair=0, first_ts=0.
REQ-031 rst overrides clear, en and any in-flight sample; the sample in that cycle is discarded.

Verification
REQ-032 en=1, three valid samples status=8'h01,8'h20,8'h03 -> viol_now[0]=1 only after third; viol_cnt[0]=1; first_pair=0, first_ts=2.
REQ-033 status=8'h1F single sample -> viol_now=6'b111111, first_pair=0; halt_mode=1 -> state=HALT next cycle, further samples ignored.
REQ-034 CNT_W=2, five samples status=8'h18 -> viol_cnt[5] saturates at 3, viol_sticky[5]=1.
REQ-035 TS_W=3, nine clean samples then status=8'h0C -> first_pair=4, first_ts=1 (wrap).
REQ-036 clear asserted with violating sample status=8'h05 -> all outputs 0 next cycle, state RUN, ts=0.
REQ-037 rst asserted in HALT with counters nonzero -> all outputs at reset values next cycle, state=IDLE.
